// File: rtl/proc_ctrl_seq.sv
// rtl/proc_ctrl_seq.sv - Lab6 processor control sequencer (T0-T3 slots); optional HALT via PROC_CTRL_HALT_EN
module proc_ctrl_seq #(
    parameter int                   SEL_W    = 3,
    parameter logic [3+2*SEL_W-1:0] RESET_IR = '0
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Run,
    input  logic [3+2*SEL_W-1:0]   DIN,
    output logic [3+2*SEL_W-1:0]   IR,
    output logic [1:0]             Tstep,
    output logic                   IRin,
    output logic                   DINout,
    output logic                   Ain,
    output logic                   Gin,
    output logic                   Gout,
    output logic                   AddSub,
    output logic [SEL_W-1:0]       RinW,
    output logic                   RinEn,
    output logic [SEL_W-1:0]       RoutW,
    output logic                   RoutEn,
    output logic                   Done
);
    localparam int IW = 3 + 2 * SEL_W;

`ifdef PROC_CTRL_HALT_EN
    typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, HALT = 3'd4} state_t;
`else
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
`endif

    state_t            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [2:0]        op;
    logic [SEL_W-1:0]  x_sel, y_sel;

    assign op    = ir_q[IW-1 -: 3];
    assign x_sel = ir_q[2*SEL_W-1 -: SEL_W];
    assign y_sel = ir_q[SEL_W-1:0];
    assign IR    = ir_q;

`ifdef PROC_CTRL_HALT_EN
    assign Tstep = (state_q == HALT) ? 2'd3 : state_q[1:0];
`else
    assign Tstep = state_q;
`endif

    // State and instruction registers; reset aborts any in-flight instruction
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= RESET_IR;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Slot decode: next slot and strobes; everything is forced low while reset is held
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        IRin    = 1'b0;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        RinW    = '0;
        RinEn   = 1'b0;
        RoutW   = '0;
        RoutEn  = 1'b0;
        Done    = 1'b0;
        if (Resetn) begin
            case (state_q)
                T0: begin
                    if (Run) begin
                        IRin    = 1'b1;
                        ir_d    = DIN;
                        state_d = T1;
                    end
                end
                T1: begin
                    state_d = T0;
                    case (op)
                        3'b000: begin
                            RoutW  = y_sel;
                            RoutEn = 1'b1;
                            RinW   = x_sel;
                            RinEn  = 1'b1;
                            Done   = 1'b1;
                        end
                        3'b001: begin
                            DINout = 1'b1;
                            RinW   = x_sel;
                            RinEn  = 1'b1;
                            Done   = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            RoutW   = x_sel;
                            RoutEn  = 1'b1;
                            Ain     = 1'b1;
                            state_d = T2;
                        end
`ifdef PROC_CTRL_HALT_EN
                        3'b111: begin
                            Done    = 1'b1;
                            state_d = HALT;
                        end
`endif
                        default: Done = 1'b1;
                    endcase
                end
                T2: begin
                    RoutW   = y_sel;
                    RoutEn  = 1'b1;
                    Gin     = 1'b1;
                    AddSub  = (op == 3'b011);
                    state_d = T3;
                end
                T3: begin
                    Gout    = 1'b1;
                    RinW    = x_sel;
                    RinEn   = 1'b1;
                    Done    = 1'b1;
                    state_d = T0;
                end
`ifdef PROC_CTRL_HALT_EN
                HALT: state_d = HALT;
                default: state_d = T0;
`endif
            endcase
        end
    end
endmodule
